// File: rtl/udp_payload_packer_pkg.sv
// Shared types and constants for the UDP payload packer.
// The HDR state only exists when UDP_PAYLOAD_PACKER_SEQ_HDR_EN is defined.
package udp_pkg;

`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;
`endif

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 6;  // at the default 48-bit sample width

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/udp_payload_packer_word_serializer.sv
// Loads one FIFO word and presents it a byte at a time, MSB first.
module word_serializer
  import udp_pkg::*;
#(
  parameter int DATA_WIDTH = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  adv_i,
  output logic [7:0]            byte_o,
  output logic                  first_o,
  output logic                  last_o
);
  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] sr_q;
  logic [IW-1:0]         idx_q;

  assign byte_o  = sr_q[DATA_WIDTH-1 -: 8];
  assign first_o = (idx_q == '0);
  assign last_o  = (idx_q == IW'(BPW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sr_q  <= word_i;
      idx_q <= '0;
    end else if (adv_i) begin
      sr_q  <= sr_q << 8;
      idx_q <= last_o ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/udp_payload_packer.sv
// Packs FIFO sample words into fixed-length UDP payload byte streams.
// Define UDP_PAYLOAD_PACKER_SEQ_HDR_EN to prefix each packet with a 4-byte seq_num.
module udp_payload_packer
  import udp_pkg::*;
#(
  parameter int DATA_WIDTH    = 48,
  parameter int WORDS_PER_PKT = 245,
  parameter int SEQ_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_data_valid,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  pkt_req,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  pkt_first,
  output logic                  pkt_last,
  output logic                  busy,
  output logic [SEQ_WIDTH-1:0]  seq_num
);
  localparam int WCW = $clog2(WORDS_PER_PKT + 1);

  state_e           state_q;
  logic [WCW-1:0]   wcnt_q;
  logic [SEQ_WIDTH-1:0] seq_q;

  logic       ser_load, ser_adv, ser_first, ser_last, last_word;
  logic [7:0] ser_byte;

  assign ser_load  = (state_q == ST_WAIT) && fifo_data_valid;
  assign ser_adv   = (state_q == ST_SHIFT) && byte_ready;
  assign last_word = (wcnt_q == WCW'(WORDS_PER_PKT - 1));

  word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (fifo_data),
    .adv_i   (ser_adv),
    .byte_o  (ser_byte),
    .first_o (ser_first),
    .last_o  (ser_last)
  );

  // Read strobe is combinational so the FIFO's one-cycle latency lines up with WAIT.
  assign fifo_rd = (state_q == ST_FETCH) && !fifo_empty;
  assign busy    = (state_q != ST_IDLE);
  assign seq_num = seq_q;

`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
  logic [1:0]  hidx_q;
  logic [31:0] seq32;
  logic [7:0]  hdr_byte;

  assign seq32      = 32'(seq_q);
  assign hdr_byte   = seq32[8*(3 - hidx_q) +: 8];
  assign byte_valid = (state_q == ST_SHIFT) || (state_q == ST_HDR);
  assign byte_out   = (state_q == ST_HDR) ? hdr_byte : ser_byte;
  assign pkt_first  = (state_q == ST_HDR) && (hidx_q == 2'd0);
`else
  assign byte_valid = (state_q == ST_SHIFT);
  assign byte_out   = ser_byte;
  assign pkt_first  = (state_q == ST_SHIFT) && (wcnt_q == '0) && ser_first;
`endif
  assign pkt_last = (state_q == ST_SHIFT) && last_word && ser_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      seq_q   <= '0;
`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
      hidx_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE:
          if (pkt_req && !fifo_empty) begin
`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
            state_q <= ST_HDR;
`else
            state_q <= ST_FETCH;
`endif
          end
`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
        ST_HDR:
          if (byte_ready) begin
            hidx_q <= hidx_q + 2'd1;  // wraps back to 0 for the next packet
            if (hidx_q == 2'd3) state_q <= ST_FETCH;
          end
`endif
        ST_FETCH:
          if (!fifo_empty) state_q <= ST_WAIT;
        ST_WAIT:
          state_q <= fifo_data_valid ? ST_SHIFT : ST_FETCH;
        ST_SHIFT:
          if (byte_ready && ser_last) begin
            wcnt_q  <= wcnt_q + 1'b1;
            state_q <= last_word ? ST_DONE : ST_FETCH;
          end
        ST_DONE: begin
          seq_q   <= seq_q + 1'b1;
          wcnt_q  <= '0;
          state_q <= ST_IDLE;
        end
        default:
          state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_packer.sv
// Randomised self-checking bench for udp_payload_packer against a byte-stream model.
module tb_udp_payload_packer;
  localparam int DW  = 48;
  localparam int WPP = 245;
  localparam int SW  = 32;
  localparam int BPW = DW / 8;
`ifdef UDP_PAYLOAD_PACKER_SEQ_HDR_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif
  localparam int PKT_BYTES = WPP * BPW + HB;
  localparam int MEM_WORDS = 2048;

  logic          clk, rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_data_valid, fifo_empty, fifo_rd;
  logic          pkt_req, byte_valid, byte_ready, pkt_first, pkt_last, busy;
  logic [7:0]    byte_out;
  logic [SW-1:0] seq_num;

  udp_payload_packer #(.DATA_WIDTH(DW), .WORDS_PER_PKT(WPP), .SEQ_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_data_valid(fifo_data_valid),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .pkt_req(pkt_req), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pkt_first(pkt_first),
    .pkt_last(pkt_last), .busy(busy), .seq_num(seq_num)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Sample FIFO model: one-cycle read latency, optional forced-empty gap.
  logic [DW-1:0] mem [0:MEM_WORDS-1];
  int  wr_ptr = 0;
  int  rd_ptr = 0;
  bit  gap    = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr) || gap;

  initial begin
    fifo_data       = '0;
    fifo_data_valid = 1'b0;
  end
  always @(posedge clk) begin
    fifo_data_valid <= 1'b0;
    if (fifo_rd && !fifo_empty) begin
      fifo_data       <= mem[rd_ptr];
      fifo_data_valid <= 1'b1;
      rd_ptr          <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte n of a packet whose samples start at mem[base]: optional seq header, then words MSB first.
  function automatic logic [7:0] exp_byte(input int base, input int n, input logic [SW-1:0] seq);
    logic [31:0]   s;
    logic [DW-1:0] w;
    int m;
    if (n < HB) begin
      s = 32'(seq);
      s = s >> (8 * (3 - n));
      return s[7:0];
    end
    m = n - HB;
    w = mem[base + m / BPW];
    w = w >> (8 * (BPW - 1 - m % BPW));
    return w[7:0];
  endfunction

  // mode: 0 ready always, 1 ready toggling, 2 ready random.
  task automatic run_pkt(input string tag, input int mode, input bit do_gap,
                         input int rst_at, input logic [SW-1:0] seq0);
    int base, n, cyc, gap_left;
    bit gap_done, done;
    base = rd_ptr; n = 0; cyc = 0; gap_left = 0; gap_done = 0; done = 0;
    chk({tag, "_seq_start"}, seq_num, seq0);
    pkt_req = 1'b1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       byte_ready = 1'b1;
        1:       byte_ready = ~byte_ready;
        default: byte_ready = 1'($urandom_range(0, 1));
      endcase
      if (do_gap && !gap_done && gap_left == 0 && rd_ptr == base + 100) begin
        gap = 1'b1;
        gap_left = 50;
      end
      #1;
      chk({tag, "_rd_while_empty"}, 64'(fifo_rd & fifo_empty), 0);
      if (gap_left > 0) begin
        chk({tag, "_gap_fifo_rd"}, fifo_rd, 0);
        gap_left--;
        if (gap_left == 0) begin
          chk({tag, "_gap_byte_valid"}, byte_valid, 0);
          chk({tag, "_gap_busy"}, busy, 1);
          gap = 1'b0;
          gap_done = 1'b1;
        end
      end
      if (rst_at >= 0 && n == rst_at) begin
        rst = 1'b1;
        pkt_req = 1'b0;
        #1;
        chk({tag, "_rst_byte_valid"}, byte_valid, 0);
        chk({tag, "_rst_fifo_rd"}, fifo_rd, 0);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_byte_out"}, byte_out, 0);
        chk({tag, "_rst_first_last"}, {pkt_first, pkt_last}, 0);
        chk({tag, "_rst_seq"}, seq_num, 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (byte_valid) begin
        if (n >= PKT_BYTES) begin
          chk({tag, "_overrun"}, n, PKT_BYTES - 1);
        end else begin
          chk({tag, "_byte"}, byte_out, exp_byte(base, n, seq0));
          chk({tag, "_first"}, pkt_first, 64'(n == 0));
          chk({tag, "_last"}, pkt_last, 64'(n == PKT_BYTES - 1));
        end
        if (byte_ready) begin
          n++;
          pkt_req = 1'b0;  // a started packet must not depend on pkt_req
        end
      end
      if (n == PKT_BYTES && !busy) done = 1'b1;
    end
    chk({tag, "_pkt_len"}, n, PKT_BYTES);
    chk({tag, "_seq_end"}, seq_num, seq0 + 1);
    chk({tag, "_idle_busy"}, busy, 0);
    pkt_req = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    rst = 1'b1; pkt_req = 1'b0; byte_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_fifo_rd", fifo_rd, 0);
    chk("reset_byte_valid", byte_valid, 0);
    chk("reset_byte_out", byte_out, 0);
    chk("reset_first_last", {pkt_first, pkt_last}, 0);
    chk("reset_seq", seq_num, 0);
    rst = 1'b0;

    // Request with an empty FIFO must leave the block idle.
    pkt_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("empty_busy", busy, 0);
      chk("empty_fifo_rd", fifo_rd, 0);
      chk("empty_byte_valid", byte_valid, 0);
    end
    pkt_req = 1'b0;

    for (int i = 0; i < WPP; i++) mem[i] = 48'h010203040506;
    for (int i = WPP; i < MEM_WORDS; i++) begin
      r = {$urandom(), $urandom()};
      mem[i] = r[DW-1:0];
    end
    wr_ptr = MEM_WORDS;

    run_pkt("p1_fixed",  0, 1'b0, -1,  0);
    run_pkt("p2_toggle", 1, 1'b0, -1,  1);
    run_pkt("p3_gap",    0, 1'b1, -1,  2);
    run_pkt("p4_random", 2, 1'b0, -1,  3);
    run_pkt("p5_reset",  0, 1'b0, 700, 4);
    run_pkt("p6_after",  2, 1'b0, -1,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_payload_packer.md
UDP_PAYLOAD_PACKER -- requirements
Module: udp_payload_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48: sample word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter WORDS_PER_PKT, default 245: FIFO words packed per UDP payload.
REQ-003 SHALL have parameter SEQ_WIDTH, default 32: width of the packet sequence counter.
REQ-004 SHALL have port: clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port: fifo_data  input  DATA_WIDTH  word from the sample FIFO read port.
REQ-007 SHALL have port: fifo_data_valid  input  1  fifo_data valid, one cycle after fifo_rd.
REQ-008 SHALL have port: fifo_empty  input  1  sample FIFO empty flag.
REQ-009 SHALL have port: fifo_rd  output  1  single-cycle FIFO read request.
REQ-010 SHALL have port: pkt_req  input  1  W5500 side has TX buffer space for one full payload.
REQ-011 SHALL have port: byte_out  output  8  payload byte.
REQ-012 SHALL have port: byte_valid  output  1  byte_out valid.
REQ-013 SHALL have port: byte_ready  input  1  consumer accepts byte_out.
REQ-014 SHALL have port: pkt_first  output  1  current byte is the first of its packet.
REQ-015 SHALL have port: pkt_last  output  1  current byte is the last of its packet.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port: seq_num  output  SEQ_WIDTH  count of completed packets.

Function
REQ-018 SHALL implement the states IDLE, HDR, FETCH, WAIT, SHIFT and DONE.
REQ-019 IDLE->HDR (macro on) or IDLE->FETCH (macro off) SHALL occur when pkt_req=1 and fifo_empty=0; otherwise the block SHALL stay in IDLE.
REQ-020 FETCH SHALL assert fifo_rd for exactly one cycle, only when fifo_empty=0, then go to WAIT; with fifo_empty=1 it SHALL hold in FETCH with fifo_rd=0.
REQ-021 WAIT SHALL latch fifo_data into the shift register and go to SHIFT when fifo_data_valid=1; otherwise it SHALL return to FETCH with no byte emitted.
REQ-022 SHIFT SHALL emit DATA_WIDTH/8 bytes, MSB first; a byte SHALL advance only on byte_valid&&byte_ready; byte_out SHALL stay stable while byte_valid=1 and byte_ready=0.
REQ-023 After the last byte of a word, the block SHALL go to FETCH if the word count is below WORDS_PER_PKT, else to DONE.
REQ-024 DONE SHALL increment seq_num (wrapping at 2^SEQ_WIDTH), clear the word count, and go to IDLE in one cycle.
REQ-025 pkt_first SHALL be 1 only with the first byte of a packet; pkt_last SHALL be 1 only with the final byte; both SHALL be qualified by byte_valid.
REQ-026 Once a packet starts, pkt_req deassertion SHALL NOT abort it; a FIFO underrun mid-packet SHALL stall in FETCH and never emit short packets.
REQ-027 Bytes per packet SHALL equal WORDS_PER_PKT*DATA_WIDTH/8 (1470 at defaults), plus 4 with the header enabled.
REQ-028 byte_valid SHALL be 0 in IDLE, FETCH, WAIT and DONE.

Reset
REQ-029 rst=1 SHALL force, asynchronously, state=IDLE, fifo_rd=0, byte_valid=0, byte_out=0, pkt_first=0, pkt_last=0, busy=0, seq_num=0, and all counters to 0.
REQ-030 Reset mid-packet SHALL discard the partial packet; the next packet SHALL start at the first byte with seq_num=0.

Configuration
REQ-031 With macro UDP_PAYLOAD_PACKER_SEQ_HDR_EN defined, HDR SHALL emit 4 bytes of seq_num (zero-extended or truncated to 32 bits), MSB first, before the first word, and pkt_first SHALL mark the first header byte.
REQ-032 Without UDP_PAYLOAD_PACKER_SEQ_HDR_EN, the HDR state SHALL be absent and the payload SHALL be sample bytes only; seq_num SHALL still count.

Structure
REQ-033 The state enum, BYTES_PER_WORD and HDR_BYTES=4 SHALL reside in shared package udp_pkg.
REQ-034 The byte serializer (load word, shift, byte index) SHALL be the sub-module word_serializer; the FSM and counters SHALL stay in the top.

Verification
REQ-035 Scenario: FIFO preloaded with 245 words 0x010203040506, pkt_req=1, byte_ready=1 -> 1470 bytes 01..06 repeating, pkt_first on byte 0, pkt_last on byte 1469, seq_num=1.
REQ-036 Scenario: byte_ready toggling 1/0 every cycle -> same byte stream, no byte duplicated or dropped, byte_out stable during stalls.
REQ-037 Scenario: FIFO empties after word 100 for 50 cycles -> fifo_rd=0 during the gap, byte_valid=0, packet resumes and total length is still 1470.
REQ-038 Scenario: macro on, second packet -> first 4 bytes 00 00 00 01, total 1474 bytes.
REQ-039 Scenario: rst pulsed at byte 700 -> all outputs reset that cycle; the next packet begins with a fresh word and seq_num=0.
REQ-040 Scenario: pkt_req=1 with fifo_empty=1 -> stays IDLE, busy=0, fifo_rd=0.
